// File: rtl/stencil_pkg.sv
// Shared types, default parameters and window-layout helper for the stencil window generator.
package stencil_pkg;

  typedef enum logic [0:0] {StFill, StStream} state_e;

  localparam int unsigned DefBw      = 32;
  localparam int unsigned DefSt      = 3;
  localparam int unsigned DefColumns = 6;

  // Bit offset of element (column c, row r) in a flattened window, column 0 oldest.
  function automatic int unsigned win_off(input int unsigned c, input int unsigned r,
                                          input int unsigned st, input int unsigned bw);
    return (c * st + r) * bw;
  endfunction

endpackage

// File: rtl/stencil_col_shreg.sv
// ST-deep column shift register; slot 0 holds the oldest column, slot ST-1 the newest.
module stencil_col_shreg #(
  parameter int unsigned BW = 32,
  parameter int unsigned ST = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               shift_i,
  input  logic [BW*ST-1:0]   col_i,
  output logic [BW*ST*ST-1:0] cols_next_o
);

  logic [ST-1:0][BW*ST-1:0] cols_q, cols_d;

  always_comb begin
    cols_d = cols_q;
    if (shift_i) begin
      for (int unsigned c = 0; c < ST - 1; c++) begin
        cols_d[c] = cols_q[c+1];
      end
      cols_d[ST-1] = col_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cols_q <= '0;
    end else begin
      cols_q <= cols_d;
    end
  end

  // Post-shift contents are exactly the window to register on an emitting accept.
  assign cols_next_o = cols_d;

endmodule

// File: rtl/stencil_window_gen.sv
// Streams ST x ST windows over column vectors of a COLUMNS-wide strip.
// Optional windowed element sum enabled by defining STENCIL_WINDOW_SUM_EN.
module stencil_window_gen
  import stencil_pkg::*;
#(
  parameter int unsigned BW      = DefBw,
  parameter int unsigned ST      = DefSt,
  parameter int unsigned COLUMNS = DefColumns
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [BW*ST-1:0]           io_in_data,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [BW*ST*ST-1:0]        io_out_window,
  output logic [$clog2(COLUMNS)-1:0] io_out_col_idx,
  output logic                       io_out_last
`ifdef STENCIL_WINDOW_SUM_EN
  ,
  output logic [BW+$clog2(ST*ST)-1:0] io_out_sum
`endif
);

  localparam int unsigned CW = $clog2(COLUMNS);
  localparam int unsigned WW = BW * ST * ST;
  localparam logic [CW-1:0] FillLastCol = CW'(ST - 2);
  localparam logic [CW-1:0] LastCol     = CW'(COLUMNS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic            valid_q, valid_d;
  logic [WW-1:0]   window_q, window_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;
  logic [WW-1:0]   win_next;
  logic            accept;
  logic            emit;

  assign io_in_ready = !valid_q || io_out_ready;
  assign accept      = io_in_valid && io_in_ready;
  assign emit        = accept && (state_q == StStream);

  stencil_col_shreg #(
    .BW(BW),
    .ST(ST)
  ) u_col_shreg (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .shift_i    (accept),
    .col_i      (io_in_data),
    .cols_next_o(win_next)
  );

  // STREAM means ST-1 columns of the current strip are already held.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    if (accept) begin
      col_d = (col_q == LastCol) ? '0 : col_q + CW'(1);
      unique case (state_q)
        StFill:   if (col_q == FillLastCol) state_d = StStream;
        StStream: if (col_q == LastCol) state_d = StFill;
        default:  state_d = StFill;
      endcase
    end
  end

  always_comb begin
    valid_d  = valid_q;
    window_d = window_q;
    idx_d    = idx_q;
    last_d   = last_q;
    if (emit) begin
      valid_d  = 1'b1;
      window_d = win_next;
      idx_d    = col_q;
      last_d   = (col_q == LastCol);
    end else if (io_out_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StFill;
      col_q    <= '0;
      valid_q  <= 1'b0;
      window_q <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      valid_q  <= valid_d;
      window_q <= window_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  assign io_out_valid   = valid_q;
  assign io_out_window  = window_q;
  assign io_out_col_idx = idx_q;
  assign io_out_last    = last_q;

`ifdef STENCIL_WINDOW_SUM_EN
  localparam int unsigned SW = BW + $clog2(ST * ST);

  logic [SW-1:0] sum_q, sum_d, win_sum;

  always_comb begin
    win_sum = '0;
    for (int unsigned c = 0; c < ST; c++) begin
      for (int unsigned r = 0; r < ST; r++) begin
        win_sum = win_sum + SW'(win_next[win_off(c, r, ST, BW) +: BW]);
      end
    end
    sum_d = emit ? win_sum : sum_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign io_out_sum = sum_q;
`endif

endmodule
